// File: rtl/vec_group_sequencer_pkg.sv
// Shared definitions for the RVV register-group sequencer: vlmul encodings,
// sequencer states and the architectural group-size limit.
package vec_group_sequencer_pkg;

  localparam int MAX_GRP_LIMIT = 8;

  localparam logic [2:0] VLMUL_M1   = 3'b000;
  localparam logic [2:0] VLMUL_M2   = 3'b001;
  localparam logic [2:0] VLMUL_M4   = 3'b010;
  localparam logic [2:0] VLMUL_M8   = 3'b011;
  localparam logic [2:0] VLMUL_RSVD = 3'b100;
  localparam logic [2:0] VLMUL_MF8  = 3'b101;
  localparam logic [2:0] VLMUL_MF4  = 3'b110;
  localparam logic [2:0] VLMUL_MF2  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } seq_state_e;

  // Group size for a vlmul encoding; 0 marks the reserved encoding.
  function automatic logic [3:0] vlmul_grp_size(input logic [2:0] vlmul);
    logic [3:0] n;
    case (vlmul)
      VLMUL_M1:   n = 4'd1;
      VLMUL_M2:   n = 4'd2;
      VLMUL_M4:   n = 4'd4;
      VLMUL_M8:   n = 4'd8;
      VLMUL_RSVD: n = 4'd0;
      VLMUL_MF8,
      VLMUL_MF4,
      VLMUL_MF2:  n = 4'd1;
      default:    n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vec_group_sequencer_vlmul_decode.sv
// Combinational vlmul -> group size decode with reserved-encoding, size-limit
// and register-group alignment checks. Non-vector instructions decode as N=1.
module vec_group_sequencer_vlmul_decode
  import vec_group_sequencer_pkg::*;
#(
  parameter int VREG_W  = 5,
  parameter int MAX_GRP = MAX_GRP_LIMIT
) (
  input  logic [2:0]        vlmul,
  input  logic              is_vector,
  input  logic              vs1_scalar,
  input  logic [VREG_W-1:0] vd,
  input  logic [VREG_W-1:0] vs1,
  input  logic [VREG_W-1:0] vs2,
  output logic [3:0]        grp_n,
  output logic              illegal
);

  logic [3:0]        raw_n;
  logic [VREG_W-1:0] mask;
  logic              misaligned;

  always_comb begin
    raw_n = vlmul_grp_size(vlmul);
    // N is a power of two, so a field is aligned when its low log2(N) bits are clear.
    mask  = VREG_W'(raw_n - 4'd1);
    misaligned = (|(vd & mask)) || (|(vs2 & mask)) ||
                 (!vs1_scalar && (|(vs1 & mask)));
    grp_n   = 4'd1;
    illegal = 1'b0;
    if (is_vector) begin
      grp_n   = raw_n;
      illegal = (raw_n == 4'd0) || (int'(raw_n) > MAX_GRP) || misaligned;
    end
  end

endmodule

// File: rtl/vec_group_sequencer.sv
// Expands LMUL>1 RVV instructions into one micro-op per group member and stalls
// PC/IF-ID meanwhile. Optional counters stat_uops/stat_grp_stalls: VEC_GROUP_STATS_EN.
module vec_group_sequencer
  import vec_group_sequencer_pkg::*;
#(
  parameter int VREG_W  = 5,
  parameter int MAX_GRP = MAX_GRP_LIMIT
`ifdef VEC_GROUP_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_is_vector,
  input  logic              id_vs1_scalar,
  input  logic [2:0]        vlmul,
  input  logic [VREG_W-1:0] id_vd,
  input  logic [VREG_W-1:0] id_vs1,
  input  logic [VREG_W-1:0] id_vs2,
  input  logic              hold,
  input  logic              flush,
  output logic              uop_valid,
  output logic [VREG_W-1:0] uop_vd,
  output logic [VREG_W-1:0] uop_vs1,
  output logic [VREG_W-1:0] uop_vs2,
  output logic [2:0]        uop_idx,
  output logic              uop_first,
  output logic              uop_last,
  output logic              grouping_stall,
  output logic              illegal_group
`ifdef VEC_GROUP_STATS_EN
  , output logic [STAT_W-1:0] stat_uops
  , output logic [STAT_W-1:0] stat_grp_stalls
`endif
);

  seq_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        n_lat_q, n_lat_d;
  logic [VREG_W-1:0] base_vd_q, base_vd_d;
  logic [VREG_W-1:0] base_vs1_q, base_vs1_d;
  logic [VREG_W-1:0] base_vs2_q, base_vs2_d;
  logic              base_vs1_scalar_q, base_vs1_scalar_d;

  logic [3:0]        dec_n;
  logic              dec_illegal;
  logic              is_last;
  logic              start_group;
  logic [VREG_W-1:0] cnt_ext;

  vec_group_sequencer_vlmul_decode #(
    .VREG_W  (VREG_W),
    .MAX_GRP (MAX_GRP)
  ) u_vlmul_decode (
    .vlmul      (vlmul),
    .is_vector  (id_is_vector),
    .vs1_scalar (id_vs1_scalar),
    .vd         (id_vd),
    .vs1        (id_vs1),
    .vs2        (id_vs2),
    .grp_n      (dec_n),
    .illegal    (dec_illegal)
  );

  assign is_last     = ({1'b0, cnt_q} == (n_lat_q - 4'd1));
  assign start_group = id_valid && !dec_illegal && (dec_n != 4'd1);
  assign cnt_ext     = VREG_W'(cnt_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt_q             <= 3'd0;
      n_lat_q           <= 4'd1;
      base_vd_q         <= '0;
      base_vs1_q        <= '0;
      base_vs2_q        <= '0;
      base_vs1_scalar_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      n_lat_q           <= n_lat_d;
      base_vd_q         <= base_vd_d;
      base_vs1_q        <= base_vs1_d;
      base_vs2_q        <= base_vs2_d;
      base_vs1_scalar_q <= base_vs1_scalar_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    n_lat_d           = n_lat_q;
    base_vd_d         = base_vd_q;
    base_vs1_d        = base_vs1_q;
    base_vs2_d        = base_vs2_q;
    base_vs1_scalar_d = base_vs1_scalar_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Member 0 issues straight from IF/ID; only a group needs latching.
          if (start_group && !hold) begin
            state_d           = SEQ;
            cnt_d             = 3'd1;
            n_lat_d           = dec_n;
            base_vd_d         = id_vd;
            base_vs1_d        = id_vs1;
            base_vs2_d        = id_vs2;
            base_vs1_scalar_d = id_vs1_scalar;
          end
        end
        SEQ: begin
          if (!hold) begin
            if (is_last) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    uop_valid      = 1'b0;
    uop_vd         = '0;
    uop_vs1        = '0;
    uop_vs2        = '0;
    uop_idx        = 3'd0;
    uop_first      = 1'b0;
    uop_last       = 1'b0;
    grouping_stall = 1'b0;
    illegal_group  = 1'b0;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (id_valid) begin
            if (dec_illegal) begin
              illegal_group = 1'b1;
            end else begin
              uop_valid      = 1'b1;
              uop_vd         = id_vd;
              uop_vs1        = id_vs1;
              uop_vs2        = id_vs2;
              uop_first      = 1'b1;
              uop_last       = (dec_n == 4'd1);
              grouping_stall = (dec_n != 4'd1);
            end
          end
        end
        SEQ: begin
          uop_valid      = 1'b1;
          uop_vd         = base_vd_q + cnt_ext;
          uop_vs2        = base_vs2_q + cnt_ext;
          uop_vs1        = base_vs1_scalar_q ? base_vs1_q : (base_vs1_q + cnt_ext);
          uop_idx        = cnt_q;
          uop_last       = is_last;
          grouping_stall = !is_last;
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_GROUP_STATS_EN
  logic [STAT_W-1:0] stat_uops_q, stat_uops_d;
  logic [STAT_W-1:0] stat_grp_stalls_q, stat_grp_stalls_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_uops_q       <= '0;
      stat_grp_stalls_q <= '0;
    end else begin
      stat_uops_q       <= stat_uops_d;
      stat_grp_stalls_q <= stat_grp_stalls_d;
    end
  end

  // Both counters saturate rather than wrap.
  always_comb begin
    stat_uops_d       = stat_uops_q;
    stat_grp_stalls_d = stat_grp_stalls_q;
    if (uop_valid && !hold && !flush && (stat_uops_q != '1))
      stat_uops_d = stat_uops_q + 1'b1;
    if (grouping_stall && !hold && (stat_grp_stalls_q != '1))
      stat_grp_stalls_d = stat_grp_stalls_q + 1'b1;
  end

  assign stat_uops       = stat_uops_q;
  assign stat_grp_stalls = stat_grp_stalls_q;
`endif

endmodule
